ft60x_fifo_responder: RTL and testbench
=======================================

Name: ft60x_fifo_responder

Overview:
- Synthesizable chip-side model of the FT600/FT601 245 synchronous FIFO interface. It is the responder that ftdi_245fifo_top talks to over the usb_* pins.
- Used in simulation benches and in board-less loopback builds in place of the real FT60x.
- A host-side AXIS slave injects words for the FPGA to read (RX buffer). A host-side AXIS master returns words the FPGA wrote (TX buffer).

Parameters:
FIFO_BUS_WIDTH, 2, bus bytes: FT600=2, FT601=4.
RX_DEPTH, 1024, RX buffer depth in bus words (power of two, >=4).
TX_DEPTH, 1024, TX buffer depth in bus words (power of two, >=4).

Ports:
usb_clk  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
usb_txe_n  out  1  low = TX buffer can accept a write.
usb_rxf_n  out  1  low = RX buffer holds data.
usb_wr_n  in  1  FPGA write strobe, low active.
usb_rd_n  in  1  FPGA read strobe, low active.
usb_oe_n  in  1  FPGA request for responder to drive bus, low active.
usb_be_i  in  FIFO_BUS_WIDTH  byte enables from FPGA.
usb_be_o  out  FIFO_BUS_WIDTH  byte enables to FPGA.
usb_be_t  out  1  1 = hi-Z, 0 = drive.
usb_data_i  in  FIFO_BUS_WIDTH*8  data from FPGA.
usb_data_o  out  FIFO_BUS_WIDTH*8  data to FPGA.
usb_data_t  out  1  1 = hi-Z, 0 = drive.
host_s_tvalid / host_s_tready / host_s_tdata[W*8] / host_s_tkeep[W]  AXIS in; RX buffer input.
host_m_tvalid / host_m_tready / host_m_tdata[W*8] / host_m_tkeep[W]  AXIS out; TX buffer output.
rx_level  out  clog2(RX_DEPTH)+1  RX occupancy.
tx_level  out  clog2(TX_DEPTH)+1  TX occupancy.
proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset state:
  - usb_txe_n=1, usb_rxf_n=1.
  - usb_be_t=1, usb_data_t=1, usb_data_o=0, usb_be_o=0.
  - host_s_tready=0, host_m_tvalid=0, levels=0, proto_err=0.
  - Both buffers flushed, FSM in IDLE.
  - Reset asserted mid-transfer tri-states the bus on that same edge.
- usb_txe_n and usb_rxf_n are registered from next-state occupancy:
  - txe_n <= (tx_count_next == TX_DEPTH).
  - rxf_n <= (rx_count_next == 0).
  - Consequence: any write or read attempted while the flag is low is guaranteed to succeed.
- Write path: at an edge with wr_n=0 and txe_n=0 and oe_n=1:
  - If be_i != 0, push {be_i, data_i}.
  - If be_i == 0, discard silently.
- Illegal write conditions: wr_n=0 with txe_n=1, or wr_n=0 with oe_n=0. The write is ignored and proto_err is set.
- Read FSM states: IDLE, DRIVE.
  - IDLE -> DRIVE on an edge sampling oe_n=0 and rxf_n=0. On that edge: data_t<=0, be_t<=0, {be_o, data_o} <= RX head (show-ahead).
  - In DRIVE, an edge with rd_n=0 pops the head, and data_o/be_o <= the next head.
  - If the pop empties the RX buffer, drive data_o=0 and be_o=0 while staying in DRIVE.
  - DRIVE -> IDLE on an edge sampling oe_n=1. On that edge: data_t<=1, be_t<=1.
- Read timing rules:
  - Bus drive starts exactly 1 cycle after oe_n falls; this is the turnaround cycle.
  - The FPGA must not sample data on that first edge.
  - rd_n=0 in IDLE, or rd_n=0 with the RX buffer empty, is ignored and sets proto_err.
- Host RX side:
  - host_s_tready = !rst && rx_count < RX_DEPTH.
  - Push {tkeep, tdata} on valid&ready.
  - The push is visible on rxf_n in the cycle after the accepting edge.
- Host TX side:
  - host_m_tvalid = tx_count != 0; tdata/tkeep = TX head.
  - Pop on valid&ready.
- A simultaneous push and pop on the same buffer leaves its count unchanged. Data order is strict FIFO.
- No combinational path from any usb_* input to any usb_* output.

Decomposition:
- Package ft60x_pkg holds:
  - FSM state enum {IDLE, DRIVE}.
  - A clog2 helper.
  - The bus word struct {be, data} width function.
- One natural sub-module, ft60x_sync_fifo: single-clock, show-ahead, with count, full and empty outputs. It is instantiated twice, for RX and TX.

Test Plan:
- Reset then idle:
  - Check txe_n=0 one cycle after reset release, and rxf_n=1.
  - Check data_t=1 throughout.
- Host pushes 0x1111, 0x2222, 0x3333 (keep 2'b11):
  - FPGA drops oe_n; data_t falls 1 cycle later.
  - rd_n held low for 3 edges yields 0x1111, 0x2222, 0x3333 in order.
  - rxf_n=1 after the third pop.
- TX_DEPTH=4 with host_m_tready=0:
  - FPGA writes 5 words with wr_n held low.
  - 4 words stored, txe_n=1 after the 4th, 5th ignored, proto_err=1.
  - Set tready=1: 4 beats emerge, txe_n returns low.
- Write with be_i=2'b00:
  - Nothing stored, tx_level stays 0, proto_err=0.
- Illegal strobes:
  - oe_n=0 and wr_n=0 together -> write ignored, proto_err=1.
  - rd_n=0 while IDLE -> no pop, proto_err=1.
- Assert rst while in DRIVE with 2 words buffered:
  - Same edge: data_t=1, rx_level=0, rxf_n=1, FSM=IDLE.

Source files
------------

// File: rtl/ft60x_pkg.sv
// Shared constants and helpers for the FT60x 245 synchronous FIFO responder.
// Read FSM encodings and bus-word sizing live here.
package ft60x_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A buffered bus word is {be, data}: one enable bit plus eight data bits per byte.
  function automatic int word_bits(input int bytes);
    return bytes * 9;
  endfunction

endpackage

// File: rtl/ft60x_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy and next-cycle head lookahead.
// Instantiated once for the RX path and once for the TX path.
module ft60x_sync_fifo
  import ft60x_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic [W-1:0]         next_head,
  output logic [clog2(DEPTH):0] count,
  output logic [clog2(DEPTH):0] count_next,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic          push_ok;
  logic          pop_ok;

  assign full       = count == CAP;
  assign empty      = count == '0;
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign rd_ptr_n   = rd_ptr + AW'(pop_ok);
  assign head       = mem[rd_ptr];

  // Head after this edge; a word landing in an emptied FIFO bypasses the RAM.
  always_comb begin
    next_head = mem[rd_ptr_n];
    if (count == (AW+1)'(pop_ok))
      next_head = push_ok ? push_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft60x_fifo_responder.sv
// Chip-side model of the FT600/FT601 245 synchronous FIFO interface.
// Host AXIS ports feed the RX buffer and drain the TX buffer.
module ft60x_fifo_responder
  import ft60x_pkg::*;
#(
  parameter int FIFO_BUS_WIDTH = 2,
  parameter int RX_DEPTH       = 1024,
  parameter int TX_DEPTH       = 1024
) (
  input  logic                          usb_clk,
  input  logic                          rst,
  output logic                          usb_txe_n,
  output logic                          usb_rxf_n,
  input  logic                          usb_wr_n,
  input  logic                          usb_rd_n,
  input  logic                          usb_oe_n,
  input  logic [FIFO_BUS_WIDTH-1:0]     usb_be_i,
  output logic [FIFO_BUS_WIDTH-1:0]     usb_be_o,
  output logic                          usb_be_t,
  input  logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_i,
  output logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_o,
  output logic                          usb_data_t,
  input  logic                          host_s_tvalid,
  output logic                          host_s_tready,
  input  logic [FIFO_BUS_WIDTH*8-1:0]   host_s_tdata,
  input  logic [FIFO_BUS_WIDTH-1:0]     host_s_tkeep,
  output logic                          host_m_tvalid,
  input  logic                          host_m_tready,
  output logic [FIFO_BUS_WIDTH*8-1:0]   host_m_tdata,
  output logic [FIFO_BUS_WIDTH-1:0]     host_m_tkeep,
  output logic [clog2(RX_DEPTH):0]      rx_level,
  output logic [clog2(TX_DEPTH):0]      tx_level,
  output logic                          proto_err
);

  localparam int WW  = word_bits(FIFO_BUS_WIDTH);
  localparam int RAW = clog2(RX_DEPTH);
  localparam int TAW = clog2(TX_DEPTH);
  localparam logic [TAW:0] TX_CAP = (TAW+1)'(TX_DEPTH);

  logic [0:0]    state;
  logic [WW-1:0] rx_head;
  logic [WW-1:0] rx_next_head;
  logic [RAW:0]  rx_count_next;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop;
  logic [WW-1:0] tx_head;
  logic [WW-1:0] tx_next_head;
  logic [TAW:0]  tx_count_next;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          wr_bad;
  logic          rd_bad;
  logic          unused_tx;

  assign tx_push = !usb_wr_n && !usb_txe_n && usb_oe_n && |usb_be_i;
  assign rx_pop  = state == ST_DRIVE && !usb_rd_n && !rx_empty;
  assign wr_bad  = !usb_wr_n && (usb_txe_n || !usb_oe_n);
  assign rd_bad  = !usb_rd_n && (state == ST_IDLE || rx_empty);

  assign host_s_tready = !rst && !rx_full;
  assign host_m_tvalid = !tx_empty;
  assign {host_m_tkeep, host_m_tdata} = tx_head;
  assign unused_tx = ^{tx_next_head, tx_full};

  ft60x_sync_fifo #(.W(WW), .DEPTH(RX_DEPTH)) u_rx (
    .clk        (usb_clk),
    .rst        (rst),
    .push       (host_s_tvalid),
    .push_data  ({host_s_tkeep, host_s_tdata}),
    .pop        (rx_pop),
    .head       (rx_head),
    .next_head  (rx_next_head),
    .count      (rx_level),
    .count_next (rx_count_next),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  ft60x_sync_fifo #(.W(WW), .DEPTH(TX_DEPTH)) u_tx (
    .clk        (usb_clk),
    .rst        (rst),
    .push       (tx_push),
    .push_data  ({usb_be_i, usb_data_i}),
    .pop        (host_m_tready),
    .head       (tx_head),
    .next_head  (tx_next_head),
    .count      (tx_level),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      usb_txe_n  <= 1'b1;
      usb_rxf_n  <= 1'b1;
      usb_data_t <= 1'b1;
      usb_be_t   <= 1'b1;
      usb_data_o <= '0;
      usb_be_o   <= '0;
      proto_err  <= 1'b0;
    end else begin
      // Flags track next-state occupancy so a strobe seen while low always lands.
      usb_txe_n <= tx_count_next == TX_CAP;
      usb_rxf_n <= rx_count_next == '0;
      if (wr_bad || rd_bad)
        proto_err <= 1'b1;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (!usb_oe_n && !usb_rxf_n) begin
            state      <= ST_DRIVE;
            usb_data_t <= 1'b0;
            usb_be_t   <= 1'b0;
            {usb_be_o, usb_data_o} <= rx_head;
          end
        end
        (state == ST_DRIVE): begin
          if (usb_oe_n) begin
            state      <= ST_IDLE;
            usb_data_t <= 1'b1;
            usb_be_t   <= 1'b1;
            usb_data_o <= '0;
            usb_be_o   <= '0;
          end else begin
            {usb_be_o, usb_data_o} <= rx_next_head;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft60x_fifo_responder.sv
// Directed and randomized bench for ft60x_fifo_responder.
// Expected values come from queue-based models of the RX/TX buffers and bus ownership.
module tb_ft60x_fifo_responder;

  localparam int BW  = 2;
  localparam int RXD = 8;
  localparam int TXD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        usb_txe_n;
  logic        usb_rxf_n;
  logic        usb_wr_n;
  logic        usb_rd_n;
  logic        usb_oe_n;
  logic [1:0]  usb_be_i;
  logic [1:0]  usb_be_o;
  logic        usb_be_t;
  logic [15:0] usb_data_i;
  logic [15:0] usb_data_o;
  logic        usb_data_t;
  logic        host_s_tvalid;
  logic        host_s_tready;
  logic [15:0] host_s_tdata;
  logic [1:0]  host_s_tkeep;
  logic        host_m_tvalid;
  logic        host_m_tready;
  logic [15:0] host_m_tdata;
  logic [1:0]  host_m_tkeep;
  logic [3:0]  rx_level;
  logic [2:0]  tx_level;
  logic        proto_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [17:0] rxq[$];
  logic [17:0] txq[$];
  bit          drv;

  ft60x_fifo_responder #(
    .FIFO_BUS_WIDTH(BW),
    .RX_DEPTH(RXD),
    .TX_DEPTH(TXD)
  ) dut (
    .usb_clk       (clk),
    .rst           (rst),
    .usb_txe_n     (usb_txe_n),
    .usb_rxf_n     (usb_rxf_n),
    .usb_wr_n      (usb_wr_n),
    .usb_rd_n      (usb_rd_n),
    .usb_oe_n      (usb_oe_n),
    .usb_be_i      (usb_be_i),
    .usb_be_o      (usb_be_o),
    .usb_be_t      (usb_be_t),
    .usb_data_i    (usb_data_i),
    .usb_data_o    (usb_data_o),
    .usb_data_t    (usb_data_t),
    .host_s_tvalid (host_s_tvalid),
    .host_s_tready (host_s_tready),
    .host_s_tdata  (host_s_tdata),
    .host_s_tkeep  (host_s_tkeep),
    .host_m_tvalid (host_m_tvalid),
    .host_m_tready (host_m_tready),
    .host_m_tdata  (host_m_tdata),
    .host_m_tkeep  (host_m_tkeep),
    .rx_level      (rx_level),
    .tx_level      (tx_level),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [17:0] w);
    host_s_tvalid = 1'b1;
    {host_s_tkeep, host_s_tdata} = w;
    tick();
    host_s_tvalid = 1'b0;
    rxq.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rxq.delete();
    txq.delete();
    drv = 1'b0;
  endtask

  initial begin
    int n_rx;
    int n_tx;
    logic [17:0] w;
    rst = 1'b1;
    usb_wr_n = 1'b1;
    usb_rd_n = 1'b1;
    usb_oe_n = 1'b1;
    usb_be_i = '0;
    usb_data_i = '0;
    host_s_tvalid = 1'b0;
    host_s_tdata = '0;
    host_s_tkeep = '0;
    host_m_tready = 1'b0;
    drv = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_txe", 32'(usb_txe_n), 32'd1);
    chk("rst_rxf", 32'(usb_rxf_n), 32'd1);
    chk("rst_dt", 32'(usb_data_t), 32'd1);
    chk("rst_bt", 32'(usb_be_t), 32'd1);
    chk("rst_bus", 32'({usb_be_o, usb_data_o}), 32'd0);
    chk("rst_srdy", 32'(host_s_tready), 32'd0);
    chk("rst_mval", 32'(host_m_tvalid), 32'd0);
    chk("rst_lvl", 32'({rx_level, tx_level}), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_txe", 32'(usb_txe_n), 32'd0);
    chk("idle_rxf", 32'(usb_rxf_n), 32'd1);
    chk("idle_dt", 32'(usb_data_t), 32'd1);

    // three-word read burst
    host_push({2'b11, 16'h1111});
    chk("rd_rxf0", 32'(usb_rxf_n), 32'd0);
    host_push({2'b11, 16'h2222});
    host_push({2'b11, 16'h3333});
    chk("rd_lvl", 32'(rx_level), 32'd3);
    usb_oe_n = 1'b0;
    chk("rd_turn", 32'(usb_data_t), 32'd1);
    tick();
    chk("rd_dt", 32'(usb_data_t), 32'd0);
    chk("rd_bt", 32'(usb_be_t), 32'd0);
    usb_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_word", 32'({usb_be_o, usb_data_o}), 32'(rxq.pop_front()));
      tick();
    end
    usb_rd_n = 1'b1;
    chk("rd_rxf1", 32'(usb_rxf_n), 32'd1);
    chk("rd_zero", 32'({usb_be_o, usb_data_o}), 32'd0);
    chk("rd_hold", 32'(usb_data_t), 32'd0);
    chk("rd_perr", 32'(proto_err), 32'd0);
    usb_oe_n = 1'b1;
    tick();
    chk("rd_rel", 32'(usb_data_t), 32'd1);

    // overfill TX with tready low
    usb_wr_n = 1'b0;
    usb_be_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      usb_data_i = 16'($urandom);
      if (txq.size() < TXD) txq.push_back({usb_be_i, usb_data_i});
      tick();
      if (i == 3) chk("tx_full", 32'(usb_txe_n), 32'd1);
    end
    usb_wr_n = 1'b1;
    chk("tx_lvl", 32'(tx_level), 32'd4);
    chk("tx_perr", 32'(proto_err), 32'd1);
    host_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_mval", 32'(host_m_tvalid), 32'd1);
      chk("tx_mdat", 32'({host_m_tkeep, host_m_tdata}), 32'(txq.pop_front()));
      tick();
    end
    host_m_tready = 1'b0;
    chk("tx_drain", 32'(host_m_tvalid), 32'd0);
    chk("tx_txe", 32'(usb_txe_n), 32'd0);

    // zero byte-enable write is dropped
    do_reset();
    usb_wr_n = 1'b0;
    usb_be_i = 2'b00;
    usb_data_i = 16'hbeef;
    tick();
    usb_wr_n = 1'b1;
    chk("be0_lvl", 32'(tx_level), 32'd0);
    chk("be0_perr", 32'(proto_err), 32'd0);

    // write while oe_n is low
    usb_oe_n = 1'b0;
    usb_wr_n = 1'b0;
    usb_be_i = 2'b11;
    tick();
    usb_wr_n = 1'b1;
    usb_oe_n = 1'b1;
    chk("wroe_lvl", 32'(tx_level), 32'd0);
    chk("wroe_perr", 32'(proto_err), 32'd1);

    // read strobe while idle
    do_reset();
    host_push({2'b01, 16'h00a5});
    usb_rd_n = 1'b0;
    tick();
    usb_rd_n = 1'b1;
    chk("rdid_lvl", 32'(rx_level), 32'd1);
    chk("rdid_perr", 32'(proto_err), 32'd1);

    // reset while driving
    do_reset();
    host_push({2'b11, 16'h0a0a});
    host_push({2'b11, 16'h0b0b});
    usb_oe_n = 1'b0;
    tick();
    chk("rstd_drv", 32'(usb_data_t), 32'd0);
    rst = 1'b1;
    tick();
    chk("rstd_dt", 32'(usb_data_t), 32'd1);
    chk("rstd_lvl", 32'(rx_level), 32'd0);
    chk("rstd_rxf", 32'(usb_rxf_n), 32'd1);
    rst = 1'b0;
    tick();
    chk("rstd_idle", 32'(usb_data_t), 32'd1);
    usb_oe_n = 1'b1;
    do_reset();

    // randomized traffic against the queue model
    for (int blk = 0; blk < 12; blk++) begin
      usb_oe_n = (blk % 2 == 1) ? 1'b0 : 1'b1;
      for (int c = 0; c < 25; c++) begin
        host_s_tvalid = 1'($urandom_range(0, 1));
        host_s_tdata  = 16'($urandom);
        host_s_tkeep  = 2'($urandom);
        host_m_tready = $urandom_range(0, 3) != 0;
        usb_wr_n = 1'b1;
        usb_rd_n = 1'b1;
        if (usb_oe_n && txq.size() < TXD && $urandom_range(0, 2) != 0) begin
          usb_wr_n   = 1'b0;
          usb_be_i   = 2'($urandom);
          usb_data_i = 16'($urandom);
        end
        if (!usb_oe_n && drv && rxq.size() > 0 && $urandom_range(0, 1) != 0)
          usb_rd_n = 1'b0;
        n_rx = rxq.size();
        n_tx = txq.size();
        chk("r_txe", 32'(usb_txe_n), 32'(n_tx == TXD));
        chk("r_rxf", 32'(usb_rxf_n), 32'(n_rx == 0));
        chk("r_srdy", 32'(host_s_tready), 32'(n_rx < RXD));
        chk("r_mval", 32'(host_m_tvalid), 32'(n_tx != 0));
        chk("r_lvl", 32'({rx_level, tx_level}), 32'({4'(n_rx), 3'(n_tx)}));
        chk("r_dt", 32'(usb_data_t), 32'(!drv));
        if (n_tx > 0)
          chk("r_mdat", 32'({host_m_tkeep, host_m_tdata}), 32'(txq[0]));
        if (drv) begin
          w = (n_rx > 0) ? rxq[0] : 18'd0;
          chk("r_dout", 32'({usb_be_o, usb_data_o}), 32'(w));
        end
        if (!usb_rd_n) void'(rxq.pop_front());
        if (host_s_tvalid && n_rx < RXD) rxq.push_back({host_s_tkeep, host_s_tdata});
        if (host_m_tready && n_tx > 0) void'(txq.pop_front());
        if (!usb_wr_n && usb_be_i != 2'b00) txq.push_back({usb_be_i, usb_data_i});
        if (!drv && !usb_oe_n && n_rx > 0) drv = 1'b1;
        else if (drv && usb_oe_n) drv = 1'b0;
        tick();
      end
    end
    host_s_tvalid = 1'b0;
    usb_wr_n = 1'b1;
    usb_rd_n = 1'b1;
    chk("r_perr", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
